// File: rtl/screensaver_pkg.sv
// Shared constants, state encoding and palette helper for the logo bounce controller.
package screensaver_pkg;

    localparam int POS_W        = 10;
    localparam int STEP_W       = 4;
    localparam int COLOR_W      = 3;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [COLOR_W-1:0] COLOR_FIRST = 3'd1;
    localparam logic [COLOR_W-1:0] COLOR_LAST  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP_X = 2'd1,
        ST_STEP_Y = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Palette index 0 is black, so the tint cycles 1..7 and skips it.
    function automatic logic [COLOR_W-1:0] next_color(input logic [COLOR_W-1:0] c);
        return (c == COLOR_LAST) ? COLOR_FIRST : c + 1'b1;
    endfunction

endpackage

// File: rtl/logo_bounce_controller_axis_stepper.sv
// One axis of motion: advance by step, clamp at 0 / limit and reflect.
module axis_stepper
    import screensaver_pkg::*;
(
    input  logic              en_i,
    input  logic [POS_W-1:0]  pos_i,
    input  logic              dir_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [POS_W-1:0]  limit_i,
    output logic [POS_W-1:0]  pos_o,
    output logic              dir_o,
    output logic              reflect_o
);

    logic [POS_W:0] pos_ext;
    logic [POS_W:0] step_ext;
    logic [POS_W:0] sum;

    // Widened by one bit so pos+step never wraps before the limit compare.
    always_comb begin
        pos_ext   = {1'b0, pos_i};
        step_ext  = {{(POS_W+1-STEP_W){1'b0}}, step_i};
        sum       = pos_ext + step_ext;
        pos_o     = pos_i;
        dir_o     = dir_i;
        reflect_o = 1'b0;
        if (en_i) begin
            if (dir_i) begin
                if (sum >= {1'b0, limit_i}) begin
                    pos_o     = limit_i;
                    dir_o     = 1'b0;
                    reflect_o = 1'b1;
                end else begin
                    pos_o = sum[POS_W-1:0];
                end
            end else begin
                if (pos_ext <= step_ext) begin
                    pos_o     = '0;
                    dir_o     = 1'b1;
                    reflect_o = 1'b1;
                end else begin
                    pos_o = pos_i - POS_W'(step_i);
                end
            end
        end
    end

endmodule

// File: rtl/logo_bounce_controller.sv
// Per-frame logo motion: X step, Y step, then atomic commit of position/colour.
module logo_bounce_controller
    import screensaver_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int LOGO_W   = 128,
    parameter int LOGO_H   = 64,
    parameter int X_INIT   = 0,
    parameter int Y_INIT   = 0
) (
    input  logic               clk_25_175,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               pause,
    input  logic [2:0]         speed,
    output logic [POS_W-1:0]   logo_x,
    output logic [POS_W-1:0]   logo_y,
    output logic [COLOR_W-1:0] color_idx,
    output logic               bounce,
    output logic               corner,
    output logic               busy
);

    localparam logic [POS_W-1:0] X_MAX = POS_W'(H_ACTIVE - LOGO_W);
    localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_ACTIVE - LOGO_H);
    localparam logic [POS_W-1:0] X_RST = POS_W'(X_INIT);
    localparam logic [POS_W-1:0] Y_RST = POS_W'(Y_INIT);

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_q;
    logic [POS_W-1:0]   x_w_q, y_w_q;
    logic               refl_x_q, refl_y_q;
    logic               dir_x_q, dir_y_q;
    logic [POS_W-1:0]   logo_x_q, logo_y_q;
    logic [COLOR_W-1:0] color_q;
    logic               bounce_q, corner_q, busy_q;

    logic [POS_W-1:0]   nx_x, nx_y;
    logic               ndir_x, ndir_y, rfl_x, rfl_y;
    logic               start;

    assign start = frame_start && !pause;

    // Both steppers read the committed position; results land in working regs
    // so the pixel path keeps seeing the old frame until COMMIT.
    axis_stepper u_step_x (
        .en_i      (state_q == ST_STEP_X),
        .pos_i     (logo_x_q),
        .dir_i     (dir_x_q),
        .step_i    (step_q),
        .limit_i   (X_MAX),
        .pos_o     (nx_x),
        .dir_o     (ndir_x),
        .reflect_o (rfl_x)
    );

    axis_stepper u_step_y (
        .en_i      (state_q == ST_STEP_Y),
        .pos_i     (logo_y_q),
        .dir_i     (dir_y_q),
        .step_i    (step_q),
        .limit_i   (Y_MAX),
        .pos_o     (nx_y),
        .dir_o     (ndir_y),
        .reflect_o (rfl_y)
    );

    // Fixed four-state walk; frame_start outside IDLE is dropped, not queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_STEP_X;
            ST_STEP_X: state_d = ST_STEP_Y;
            ST_STEP_Y: state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath and commit registers; reset wipes any in-flight update.
    always_ff @(posedge clk_25_175) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            step_q   <= STEP_W'(1);
            x_w_q    <= X_RST;
            y_w_q    <= Y_RST;
            refl_x_q <= 1'b0;
            refl_y_q <= 1'b0;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            logo_x_q <= X_RST;
            logo_y_q <= Y_RST;
            color_q  <= COLOR_FIRST;
            bounce_q <= 1'b0;
            corner_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bounce_q <= 1'b0;
            corner_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        step_q   <= {1'b0, speed} + STEP_W'(1);
                        refl_x_q <= 1'b0;
                        refl_y_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_STEP_X: begin
                    x_w_q    <= nx_x;
                    dir_x_q  <= ndir_x;
                    refl_x_q <= rfl_x;
                end
                ST_STEP_Y: begin
                    y_w_q    <= nx_y;
                    dir_y_q  <= ndir_y;
                    refl_y_q <= rfl_y;
                end
                ST_COMMIT: begin
                    logo_x_q <= x_w_q;
                    logo_y_q <= y_w_q;
                    bounce_q <= refl_x_q | refl_y_q;
                    corner_q <= refl_x_q & refl_y_q;
                    if (refl_x_q | refl_y_q) color_q <= next_color(color_q);
                    busy_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign logo_x    = logo_x_q;
    assign logo_y    = logo_y_q;
    assign color_idx = color_q;
    assign bounce    = bounce_q;
    assign corner    = corner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_logo_bounce_controller.sv
// Bench for logo_bounce_controller: table vectors, hand sequences, model-driven run.
module tb_logo_bounce_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       pause;
    logic [2:0] speed;
    logic [2:0] fs;
    logic [9:0] lx [3];
    logic [9:0] ly [3];
    logic [2:0] ci [3];
    logic       bo [3];
    logic       co [3];
    logic       bz [3];

    always #5 clk = ~clk;

    // Three instances so edge and corner cases start right at the interesting spot.
    logo_bounce_controller #(.H_ACTIVE(640), .V_ACTIVE(480), .LOGO_W(128), .LOGO_H(64),
                             .X_INIT(0), .Y_INIT(0)) u0 (
        .clk_25_175(clk), .rst(rst), .frame_start(fs[0]), .pause(pause), .speed(speed),
        .logo_x(lx[0]), .logo_y(ly[0]), .color_idx(ci[0]), .bounce(bo[0]),
        .corner(co[0]), .busy(bz[0]));

    logo_bounce_controller #(.H_ACTIVE(640), .V_ACTIVE(480), .LOGO_W(128), .LOGO_H(64),
                             .X_INIT(510), .Y_INIT(100)) u1 (
        .clk_25_175(clk), .rst(rst), .frame_start(fs[1]), .pause(pause), .speed(speed),
        .logo_x(lx[1]), .logo_y(ly[1]), .color_idx(ci[1]), .bounce(bo[1]),
        .corner(co[1]), .busy(bz[1]));

    logo_bounce_controller #(.H_ACTIVE(640), .V_ACTIVE(480), .LOGO_W(128), .LOGO_H(64),
                             .X_INIT(511), .Y_INIT(415)) u2 (
        .clk_25_175(clk), .rst(rst), .frame_start(fs[2]), .pause(pause), .speed(speed),
        .logo_x(lx[2]), .logo_y(ly[2]), .color_idx(ci[2]), .bounce(bo[2]),
        .corner(co[2]), .busy(bz[2]));

    typedef struct {
        int x; int y; int c; int b; int k;
    } exp_t;

    typedef struct {
        int inst; int spd; int ex; int ey; int ec; int eb; int ek;
    } vec_t;

    exp_t sb [$];
    vec_t tbl [8];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   mx [3];
    int   my [3];
    int   mdx [3];
    int   mdy [3];
    int   mc [3];

    task automatic chk(input string nm, input int act, input int want);
        n_tot++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, want);
    endtask

    function automatic void axis(input int p, input int d, input int s, input int lim,
                                 output int np, output int nd, output int r);
        r  = 0;
        nd = d;
        if (d > 0) begin
            if (p + s >= lim) begin np = lim; nd = -1; r = 1; end
            else np = p + s;
        end else begin
            if (p - s <= 0) begin np = 0; nd = 1; r = 1; end
            else np = p - s;
        end
    endfunction

    task automatic model_reset();
        mx  = '{0, 510, 511};
        my  = '{0, 100, 415};
        mdx = '{1, 1, 1};
        mdy = '{1, 1, 1};
        mc  = '{1, 1, 1};
    endtask

    task automatic model_step(input int i, input int spd, output exp_t e);
        int nx, ny, ndx, ndy, rx, ry;
        axis(mx[i], mdx[i], spd + 1, 512, nx, ndx, rx);
        axis(my[i], mdy[i], spd + 1, 416, ny, ndy, ry);
        mx[i] = nx; my[i] = ny; mdx[i] = ndx; mdy[i] = ndy;
        if (rx != 0 || ry != 0) mc[i] = (mc[i] == 7) ? 1 : mc[i] + 1;
        e.x = nx; e.y = ny; e.c = mc[i];
        e.b = (rx != 0 || ry != 0) ? 1 : 0;
        e.k = (rx != 0 && ry != 0) ? 1 : 0;
    endtask

    // One frame: push expectation, count busy cycles, compare at commit, check pulse width.
    task automatic do_frame(input int i, input int spd, input exp_t e, input bit dbl,
                            input string tag);
        int   hi;
        exp_t g;
        @(posedge clk); #1;
        pause = 1'b0; speed = 3'(spd); fs[i] = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        fs[i] = 1'b0;
        hi = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (!bz[i]) break;
            hi++;
            if (dbl && hi == 2) fs[i] = 1'b1;
            if (dbl && hi == 3) fs[i] = 1'b0;
        end
        fs[i] = 1'b0;
        chk({tag, "_busy_cycles"}, hi, 3);
        g = sb.pop_front();
        chk({tag, "_x"}, int'(lx[i]), g.x);
        chk({tag, "_y"}, int'(ly[i]), g.y);
        chk({tag, "_color"}, int'(ci[i]), g.c);
        chk({tag, "_bounce"}, int'(bo[i]), g.b);
        chk({tag, "_corner"}, int'(co[i]), g.k);
        @(negedge clk);
        chk({tag, "_pulse_end"}, int'(bo[i]) + int'(co[i]), 0);
        chk({tag, "_idle_after"}, int'(bz[i]), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   spd;
        rst = 1'b1; pause = 1'b0; speed = 3'd0; fs = '0;
        model_reset();

        tbl[0] = '{0, 0,   1,   1, 1, 0, 0};
        tbl[1] = '{0, 7,   9,   9, 1, 0, 0};
        tbl[2] = '{1, 3, 512, 104, 2, 1, 0};
        tbl[3] = '{1, 3, 508, 108, 2, 0, 0};
        tbl[4] = '{2, 0, 512, 416, 2, 1, 1};
        tbl[5] = '{2, 0, 511, 415, 2, 0, 0};
        tbl[6] = '{2, 7, 503, 407, 2, 0, 0};
        tbl[7] = '{1, 7, 500, 116, 2, 0, 0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_x", int'(lx[0]), 0);
        chk("rst_y", int'(ly[0]), 0);
        chk("rst_color", int'(ci[0]), 1);
        chk("rst_busy", int'(bz[0]), 0);
        chk("rst_bounce", int'(bo[0]), 0);
        chk("rst_corner", int'(co[0]), 0);
        chk("rst_x_init", int'(lx[2]), 511);

        // Vector 1 also fires a second frame_start mid-update, which must be dropped.
        for (int k = 0; k < 8; k++) begin
            model_step(tbl[k].inst, tbl[k].spd, e);
            e = '{tbl[k].ex, tbl[k].ey, tbl[k].ec, tbl[k].eb, tbl[k].ek};
            do_frame(tbl[k].inst, tbl[k].spd, e, k == 1, $sformatf("vec%0d", k));
        end

        // Paused frame_start: nothing moves, busy never rises.
        @(posedge clk); #1;
        pause = 1'b1; speed = 3'd7; fs[0] = 1'b1;
        @(posedge clk); #1;
        fs[0] = 1'b0; pause = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("pause_busy", int'(bz[0]), 0);
            chk("pause_bounce", int'(bo[0]), 0);
        end
        chk("pause_x", int'(lx[0]), mx[0]);
        chk("pause_y", int'(ly[0]), my[0]);
        chk("pause_color", int'(ci[0]), mc[0]);

        // Long run against the model: many reflections, colour wraps 7 -> 1.
        for (int f = 0; f < 500; f++) begin
            spd = $urandom_range(4, 7);
            model_step(0, spd, e);
            do_frame(0, spd, e, 1'b0, (e.b == 1 && e.c == 1) ? "wrap" : "run");
        end

        // Clean reset, then reset in the middle of a corner update on instance 2.
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        speed = 3'd0; fs[2] = 1'b1;
        @(posedge clk); #1;
        fs[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_x", int'(lx[2]), 511);
        chk("midrst_y", int'(ly[2]), 415);
        chk("midrst_color", int'(ci[2]), 1);
        chk("midrst_busy", int'(bz[2]), 0);
        chk("midrst_bounce", int'(bo[2]), 0);
        chk("midrst_corner", int'(co[2]), 0);
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("midrst_no_bounce", int'(bo[2]), 0);
            chk("midrst_idle", int'(bz[2]), 0);
        end
        model_step(2, 0, e);
        do_frame(2, 0, e, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/logo_bounce_controller.md
# logo_bounce_controller

Per-frame motion scheduler for the screensaver image. It sits beside the VGA timing and pixel path, clocked by `clk_25_175`. Once per frame, on the frame-start strobe from the timing generator, it computes the next logo position, reflects at screen edges, and advances the tint colour on each bounce. It publishes the new position and colour atomically so the pixel path never sees a half-updated frame.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines.
- `LOGO_W`, 128: logo width in pixels.
- `LOGO_H`, 64: logo height in pixels.
- `X_INIT`, 0: reset x position.
- `Y_INIT`, 0: reset y position.

Ports:
- `clk_25_175`, in, 1: pixel clock, the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `frame_start`, in, 1: one-cycle pulse at the first vertical-blank line.
- `pause`, in, 1: freezes motion. Sampled with `frame_start`.
- `speed`, in, 3: step size is `speed`+1 pixels per frame. Sampled with `frame_start`.
- `logo_x`, out, 10: committed left edge of the logo.
- `logo_y`, out, 10: committed top edge of the logo.
- `color_idx`, out, 3: palette index, range 1..7. Index 0 is reserved for black.
- `bounce`, out, 1: one-cycle pulse when the commit contained at least one reflection.
- `corner`, out, 1: one-cycle pulse when x and y both reflected in the same commit.
- `busy`, out, 1: high while an update is in flight.

## Operation
- Limits: `X_MAX` = `H_ACTIVE`−`LOGO_W` (512), `Y_MAX` = `V_ACTIVE`−`LOGO_H` (416).
- Direction registers `dir_x` and `dir_y`: 1 means increasing. Reset value of both is 1.
- State machine states:
  - IDLE: waits for `frame_start`.
  - STEP_X: computes the next x.
  - STEP_Y: computes the next y.
  - COMMIT: publishes the result.
- IDLE → STEP_X when `frame_start`=1 and `pause`=0. At that edge, `speed` is latched into `step`.
- `frame_start` with `pause`=1: the FSM stays in IDLE and no output changes.
- STEP_X → STEP_Y → COMMIT → IDLE, unconditionally.
- Per-axis step rule, using a working copy `p`:
  - Increasing: if `p`+`step` ≥ MAX, then next = MAX, flip direction, set the axis reflect flag. Otherwise next = `p`+`step`.
  - Decreasing: if `p` ≤ `step`, then next = 0, flip direction, set the reflect flag. Otherwise next = `p`−`step`.
  - Compute in 11 bits so the sum cannot overflow.
  - A position already at the limit reflects again only when moving toward that limit.
- COMMIT loads `logo_x`, `logo_y`, `bounce` and `corner` in the same edge.
- Colour on reflection: if either axis reflected, `color_idx` advances by exactly 1, even for a corner.
  - Wrap is 7 → 1; 0 is never output.
- `frame_start` arriving while `busy`=1 is ignored. It is not queued.
- Reset values: `logo_x`=`X_INIT`, `logo_y`=`Y_INIT`, `color_idx`=1, `bounce`=0, `corner`=0, `busy`=0, FSM in IDLE.
- Reset mid-update: the in-flight update is discarded and no partial commit reaches the outputs.

## Timing
- `frame_start` sampled high at edge N.
- `busy`=1 during cycles N+1 through N+3.
- New `logo_x`, `logo_y` and `color_idx` are visible from N+4.
- `bounce` and `corner` are high for cycle N+4 only.
- Total latency is 4 clocks, well inside vertical blanking.
- Outputs are registered with no combinational path from inputs.
- `rst` has priority over `frame_start` in the same cycle.

## Structure
- `screensaver_pkg` holds:
  - the state enum;
  - the `POS_W`=10 constant;
  - the palette index width and `COLOR_FIRST`=1 / `COLOR_LAST`=7;
  - the default `H_ACTIVE`/`V_ACTIVE`.
- Sub-module `axis_stepper`:
  - purely combinational;
  - inputs: position, direction, step, limit;
  - outputs: next position, next direction, reflect;
  - instantiated twice (x and y) and enabled by STEP_X and STEP_Y respectively.
- The top level holds the FSM, the latched `step`, the working registers and the commit registers.

## Test plan
- Reset: hold `rst` 2 cycles. Expect `logo_x`=0, `logo_y`=0, `color_idx`=1, `busy`=0, `bounce`=0.
- Nominal step: `speed`=0, one `frame_start`. Expect `busy` high 3 cycles, then x=1, y=1 at N+4, with `bounce`=0.
- Right-edge reflect:
  - Preload x=510, `speed`=3 (step 4). Expect x=512, `bounce`=1, `corner`=0, `color_idx`=2.
  - Next frame: expect x=508.
- Corner: x=511, y=415, `speed`=0.
  - Expect x=512, y=416, `bounce`=1, `corner`=1, `color_idx` advanced by one.
  - Next frame: expect x=511, y=415.
- Pause, ignore and wrap:
  - `frame_start` with `pause`=1 → no output change, `busy` stays 0.
  - Second `frame_start` at N+2 → ignored.
  - `color_idx`=7 with a bounce → becomes 1.
- Reset mid-op: assert `rst` at N+2. Expect reset values at N+3, no `bounce` pulse, FSM in IDLE.
